d05200_otp_ctrl: RTL and testbench

Sequencer and arbiter for the 128x8 POTP macro. Two requesters share the macro: the boot loader (R0, read-only, high priority) and the OWL host command path (R1, read/program). The block generates CS/READ/PROG with programmed setup, strobe and hold timing, captures read data, and returns it over a four-phase REQ/ACK handshake. It sits between d05200_dc_top logic and the OTP_* pins of the macro.

---
 rtl/d05200_otp_pkg.sv | 29 ++
 rtl/d05200_otp_ctrl_if.sv | 36 +++
 rtl/d05200_otp_tmr.sv | 28 ++
 rtl/d05200_otp_ctrl.sv | 165 ++++++++++++++++
 tb/tb_d05200_otp_ctrl.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/d05200_otp_pkg.sv
// Shared types and constants for the POTP sequencer/arbiter.
package d05200_otp_pkg;

  localparam int unsigned OTP_ADDR_W  = 7;
  localparam int unsigned OTP_DATA_W  = 8;
  localparam int unsigned CNT_W_DEF   = 12;
  localparam int unsigned T_SETUP_DEF = 2;
  localparam int unsigned T_READ_DEF  = 4;
  localparam int unsigned T_PROG_DEF  = 2000;
  localparam int unsigned T_HOLD_DEF  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_VERIFY,
    ST_DONE
  } otp_state_e;

  // Transaction latched at grant; held stable for the whole CS window.
  typedef struct packed {
    logic                  owner;
    logic                  wr;
    logic [OTP_ADDR_W-1:0] addr;
    logic [OTP_DATA_W-1:0] wdata;
  } otp_req_t;

endpackage

// File: rtl/d05200_otp_ctrl_if.sv
// Requester handshakes plus OTP macro pins for d05200_otp_ctrl.
interface d05200_otp_ctrl_if;
  import d05200_otp_pkg::*;

  logic                  R0_REQ;
  logic [OTP_ADDR_W-1:0] R0_ADDR;
  logic                  R0_ACK;
  logic                  R1_REQ;
  logic                  R1_WR;
  logic [OTP_ADDR_W-1:0] R1_ADDR;
  logic [OTP_DATA_W-1:0] R1_WDATA;
  logic                  R1_ACK;
  logic                  R1_ERR;
  logic [OTP_DATA_W-1:0] RDATA;
  logic                  PROG_EN;
  logic                  BUSY;
  logic                  OTP_CS;
  logic                  OTP_READ;
  logic                  OTP_PROG;
  logic [OTP_ADDR_W-1:0] OTP_ADDR;
  logic [OTP_DATA_W-1:0] OTP_DATI;
  logic [OTP_DATA_W-1:0] OTP_DATO;

  modport slave (
    input  R0_REQ, R0_ADDR, R1_REQ, R1_WR, R1_ADDR, R1_WDATA, PROG_EN, OTP_DATO,
    output R0_ACK, R1_ACK, R1_ERR, RDATA, BUSY, OTP_CS, OTP_READ, OTP_PROG,
           OTP_ADDR, OTP_DATI
  );

  modport master (
    output R0_REQ, R0_ADDR, R1_REQ, R1_WR, R1_ADDR, R1_WDATA, PROG_EN, OTP_DATO,
    input  R0_ACK, R1_ACK, R1_ERR, RDATA, BUSY, OTP_CS, OTP_READ, OTP_PROG,
           OTP_ADDR, OTP_DATI
  );

endinterface

// File: rtl/d05200_otp_tmr.sv
// Phase timer: loadable down-counter that parks at zero.
module d05200_otp_tmr
  import d05200_otp_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero_c
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero_c = (cnt == '0);

endmodule

// File: rtl/d05200_otp_ctrl.sv
// POTP sequencer/arbiter: boot read port R0 outranks host port R1.
// Define OTP_VERIFY_EN to add an automatic read-back after every program.
module d05200_otp_ctrl
  import d05200_otp_pkg::*;
#(
  parameter int unsigned T_SETUP = T_SETUP_DEF,
  parameter int unsigned T_READ  = T_READ_DEF,
  parameter int unsigned T_PROG  = T_PROG_DEF,
  parameter int unsigned T_HOLD  = T_HOLD_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input logic               HCLK,
  input logic               RESET,
  d05200_otp_ctrl_if.slave  bus
);

  otp_state_e            state;
  otp_req_t              req_q;
  otp_req_t              grant_c;
  logic                  cs_q, read_q, prog_q;
  logic                  r0_ack_q, r1_ack_q, err_q, busy_q;
  logic [OTP_DATA_W-1:0] rdata_q;
  logic                  tmr_load_c, tmr_zero_c;
  logic [CNT_W-1:0]      tmr_val_c;
  logic                  owner_req_c;
`ifdef OTP_VERIFY_EN
  logic                  vfy_q;
`endif

  d05200_otp_tmr #(.CNT_W(CNT_W)) u_tmr (
    .clk      (HCLK),
    .rst      (RESET),
    .load     (tmr_load_c),
    .load_val (tmr_val_c),
    .zero_c   (tmr_zero_c)
  );

  // Fixed-priority pick; R0 is read-only so WR/WDATA are forced to zero.
  always_comb begin
    grant_c.owner = ~bus.R0_REQ;
    grant_c.wr    = bus.R0_REQ ? 1'b0 : bus.R1_WR;
    grant_c.addr  = bus.R0_REQ ? bus.R0_ADDR : bus.R1_ADDR;
    grant_c.wdata = bus.R0_REQ ? '0 : bus.R1_WDATA;
    owner_req_c   = req_q.owner ? bus.R1_REQ : bus.R0_REQ;
  end

  // Timer reload at every phase boundary, so it never has to wrap.
  always_comb begin
    tmr_load_c = 1'b0;
    tmr_val_c  = CNT_W'(T_SETUP - 1);
    case (state)
      ST_IDLE: tmr_load_c = 1'b1;
      ST_SETUP, ST_VERIFY: begin
        tmr_load_c = tmr_zero_c;
        tmr_val_c  = req_q.wr ? CNT_W'(T_PROG - 1) : CNT_W'(T_READ - 1);
      end
      ST_STROBE: begin
        tmr_load_c = tmr_zero_c | (req_q.wr & ~bus.PROG_EN);
        tmr_val_c  = CNT_W'(T_HOLD - 1);
      end
      ST_HOLD: tmr_load_c = tmr_zero_c;
      default: ;
    endcase
  end

  always_ff @(posedge HCLK or posedge RESET) begin
    if (RESET) begin
      state    <= ST_IDLE;
      req_q    <= '0;
      cs_q     <= 1'b0;
      read_q   <= 1'b0;
      prog_q   <= 1'b0;
      r0_ack_q <= 1'b0;
      r1_ack_q <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      rdata_q  <= '0;
`ifdef OTP_VERIFY_EN
      vfy_q    <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.R0_REQ || bus.R1_REQ) begin
            req_q  <= grant_c;
            busy_q <= 1'b1;
            err_q  <= 1'b0;
`ifdef OTP_VERIFY_EN
            vfy_q  <= 1'b0;
`endif
            if (grant_c.wr && !bus.PROG_EN) begin
              err_q <= 1'b1;
              state <= ST_DONE;
            end else begin
              cs_q  <= 1'b1;
              state <= ST_SETUP;
            end
          end
        end
        ST_SETUP, ST_VERIFY: begin
          if (tmr_zero_c) begin
            state  <= ST_STROBE;
            prog_q <= req_q.wr;
            read_q <= ~req_q.wr;
          end
        end
        ST_STROBE: begin
          if (req_q.wr && !bus.PROG_EN) begin
            prog_q <= 1'b0;
            err_q  <= 1'b1;
            state  <= ST_HOLD;
          end else if (tmr_zero_c) begin
            prog_q <= 1'b0;
            read_q <= 1'b0;
            state  <= ST_HOLD;
            if (!req_q.wr) rdata_q <= bus.OTP_DATO;
          end
        end
        ST_HOLD: begin
          if (tmr_zero_c) begin
`ifdef OTP_VERIFY_EN
            // Successful program re-enters setup as a read of the same cell.
            if (req_q.wr && !err_q) begin
              req_q.wr <= 1'b0;
              vfy_q    <= 1'b1;
              state    <= ST_VERIFY;
            end else begin
              cs_q  <= 1'b0;
              state <= ST_DONE;
              if (vfy_q) err_q <= (rdata_q != req_q.wdata);
            end
`else
            cs_q  <= 1'b0;
            state <= ST_DONE;
`endif
          end
        end
        ST_DONE: begin
          if (!(r0_ack_q || r1_ack_q)) begin
            r0_ack_q <= ~req_q.owner;
            r1_ack_q <= req_q.owner;
          end else if (!owner_req_c) begin
            r0_ack_q <= 1'b0;
            r1_ack_q <= 1'b0;
            busy_q   <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.R0_ACK   = r0_ack_q;
  assign bus.R1_ACK   = r1_ack_q;
  assign bus.R1_ERR   = err_q;
  assign bus.RDATA    = rdata_q;
  assign bus.BUSY     = busy_q;
  assign bus.OTP_CS   = cs_q;
  assign bus.OTP_READ = read_q;
  assign bus.OTP_PROG = prog_q;
  assign bus.OTP_ADDR = req_q.addr;
  assign bus.OTP_DATI = req_q.wdata;

endmodule

// File: tb/tb_d05200_otp_ctrl.sv
// Self-checking bench for d05200_otp_ctrl; expectations follow OTP_VERIFY_EN if defined.
module tb_d05200_otp_ctrl;

  typedef struct {
    bit         owner;
    logic [7:0] rdata;
    logic       err;
    int         lat;
  } exp_t;

  logic HCLK = 1'b0;
  logic RESET;
  int   checks = 0;
  int   errors = 0;

  exp_t       exp_q[$];
  exp_t       e;
  int         lat, cs_n, rd_n, pg_n, rd_first, bad, ack_w, ackcnt;
  logic [7:0] rd, last_rdata;
  logic       er;
  bit         to;

  d05200_otp_ctrl_if bus ();

  d05200_otp_ctrl dut (
    .HCLK  (HCLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 HCLK = ~HCLK;

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  // Drives one transaction; the first clock edge is the grant edge (k=0).
  task automatic run_txn(input bit owner, input bit wr, input logic [6:0] addr,
                         input logic [7:0] wdata, input int drop_k, input int pe_drop_k,
                         input int hold_extra, output int o_lat, output int o_cs,
                         output int o_rd, output int o_pg, output int o_rd_first,
                         output int o_bad, output int o_ack_w, output logic [7:0] o_rdata,
                         output logic o_err, output bit o_to);
    logic ack;
    int   k;
    o_lat = -1; o_cs = 0; o_rd = 0; o_pg = 0; o_rd_first = -1; o_bad = 0;
    o_ack_w = 0; o_rdata = 'x; o_err = 'x; o_to = 1'b0;
    if (owner) begin
      bus.R1_REQ = 1'b1; bus.R1_WR = wr; bus.R1_ADDR = addr; bus.R1_WDATA = wdata;
    end else begin
      bus.R0_REQ = 1'b1; bus.R0_ADDR = addr;
    end
    ack = 1'b0;
    k   = 0;
    while (!ack && k < 3000) begin
      tick();
      ack = owner ? bus.R1_ACK : bus.R0_ACK;
      if (ack) begin
        o_lat = k;
      end else begin
        if (bus.OTP_CS) begin
          o_cs++;
          if (bus.OTP_ADDR !== addr || (wr && bus.OTP_DATI !== wdata)) o_bad++;
        end
        if (bus.OTP_READ) begin
          if (o_rd == 0) o_rd_first = k;
          o_rd++;
        end
        if (bus.OTP_PROG) o_pg++;
        if (k == 3) begin
          if (owner) begin bus.R1_ADDR = addr ^ 7'h55; bus.R1_WDATA = ~wdata; end
          else bus.R0_ADDR = addr ^ 7'h55;
        end
        if (k == drop_k) begin
          if (owner) bus.R1_REQ = 1'b0; else bus.R0_REQ = 1'b0;
        end
        if (k == pe_drop_k) bus.PROG_EN = 1'b0;
        k++;
      end
    end
    if (!ack) begin
      o_to = 1'b1;
      bus.R0_REQ = 1'b0;
      bus.R1_REQ = 1'b0;
      return;
    end
    o_rdata = bus.RDATA;
    o_err   = bus.R1_ERR;
    o_ack_w = 1;
    repeat (hold_extra) begin
      tick();
      if (owner ? bus.R1_ACK : bus.R0_ACK) o_ack_w++;
    end
    if (owner) bus.R1_REQ = 1'b0; else bus.R0_REQ = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (owner ? bus.R1_ACK : bus.R0_ACK) o_ack_w++;
      else break;
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    bus.R0_REQ = 0; bus.R0_ADDR = 0; bus.R1_REQ = 0; bus.R1_WR = 0;
    bus.R1_ADDR = 0; bus.R1_WDATA = 0; bus.PROG_EN = 1; bus.OTP_DATO = 0;
    repeat (3) tick();
    checks++; if ({bus.R0_ACK, bus.R1_ACK, bus.R1_ERR, bus.BUSY} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b want 0000", {bus.R0_ACK, bus.R1_ACK, bus.R1_ERR, bus.BUSY}); end
    checks++; if ({bus.OTP_CS, bus.OTP_READ, bus.OTP_PROG} !== 3'b0) begin errors++; $display("FAIL reset_strobes got %b want 000", {bus.OTP_CS, bus.OTP_READ, bus.OTP_PROG}); end
    checks++; if ({bus.RDATA, bus.OTP_ADDR, bus.OTP_DATI} !== 23'b0) begin errors++; $display("FAIL reset_data got %h want 0", {bus.RDATA, bus.OTP_ADDR, bus.OTP_DATI}); end
    RESET = 1'b0;
    tick();
    last_rdata = 8'h00;
  endtask

  task automatic test_read();
    bus.OTP_DATO = 8'hA5;
    exp_q.push_back('{owner: 1'b1, rdata: 8'hA5, err: 1'b0, lat: 9});
    run_txn(1'b1, 1'b0, 7'h05, 8'h00, -1, -1, 3, lat, cs_n, rd_n, pg_n, rd_first, bad, ack_w, rd, er, to);
    e = exp_q.pop_front();
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL read_timeout got %0d want 0", to); end
    checks++; if (lat !== e.lat) begin errors++; $display("FAIL read_lat got %0d want %0d", lat, e.lat); end
    checks++; if (rd !== e.rdata) begin errors++; $display("FAIL read_rdata got %h want %h", rd, e.rdata); end
    checks++; if (er !== e.err) begin errors++; $display("FAIL read_err got %b want %b", er, e.err); end
    checks++; if (cs_n !== 8) begin errors++; $display("FAIL read_cs_cycles got %0d want 8", cs_n); end
    checks++; if (rd_n !== 4 || rd_first !== 2) begin errors++; $display("FAIL read_strobe got %0d@%0d want 4@2", rd_n, rd_first); end
    checks++; if (pg_n !== 0) begin errors++; $display("FAIL read_prog got %0d want 0", pg_n); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL read_addr_stable got %0d want 0", bad); end
    checks++; if (ack_w !== 4) begin errors++; $display("FAIL read_ack_width got %0d want 4", ack_w); end
    checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL read_busy_after got %b want 0", bus.BUSY); end
    last_rdata = 8'hA5;
  endtask

  task automatic test_arbitration();
    bus.OTP_DATO = 8'h5A;
    bus.R1_REQ = 1'b1; bus.R1_WR = 1'b0; bus.R1_ADDR = 7'h7F; bus.R1_WDATA = 8'h00;
    exp_q.push_back('{owner: 1'b0, rdata: 8'h5A, err: 1'b0, lat: 9});
    run_txn(1'b0, 1'b0, 7'h00, 8'h00, -1, -1, 0, lat, cs_n, rd_n, pg_n, rd_first, bad, ack_w, rd, er, to);
    e = exp_q.pop_front();
    checks++; if (to !== 1'b0 || lat !== e.lat) begin errors++; $display("FAIL arb_r0_lat got %0d want %0d", lat, e.lat); end
    checks++; if (bad !== 0 || cs_n !== 8) begin errors++; $display("FAIL arb_r0_addr got bad=%0d cs=%0d want 0/8", bad, cs_n); end
    checks++; if (rd !== e.rdata) begin errors++; $display("FAIL arb_r0_rdata got %h want %h", rd, e.rdata); end
    bus.OTP_DATO = 8'h96;
    exp_q.push_back('{owner: 1'b1, rdata: 8'h96, err: 1'b0, lat: 9});
    run_txn(1'b1, 1'b0, 7'h7F, 8'h00, -1, -1, 0, lat, cs_n, rd_n, pg_n, rd_first, bad, ack_w, rd, er, to);
    e = exp_q.pop_front();
    checks++; if (to !== 1'b0 || lat !== e.lat) begin errors++; $display("FAIL arb_r1_lat got %0d want %0d", lat, e.lat); end
    checks++; if (bad !== 0 || cs_n !== 8) begin errors++; $display("FAIL arb_r1_addr got bad=%0d cs=%0d want 0/8", bad, cs_n); end
    checks++; if (rd !== e.rdata || er !== e.err) begin errors++; $display("FAIL arb_r1_data got %h/%b want %h/%b", rd, er, e.rdata, e.err); end
    last_rdata = 8'h96;
  endtask

  task automatic test_program();
    int exp_cs, exp_rd;
    bus.PROG_EN  = 1'b1;
    bus.OTP_DATO = 8'h3D;
`ifdef OTP_VERIFY_EN
    exp_q.push_back('{owner: 1'b1, rdata: 8'h3D, err: 1'b1, lat: 2013});
    exp_cs = 2012; exp_rd = 4;
`else
    exp_q.push_back('{owner: 1'b1, rdata: last_rdata, err: 1'b0, lat: 2005});
    exp_cs = 2004; exp_rd = 0;
`endif
    run_txn(1'b1, 1'b1, 7'h10, 8'h3C, -1, -1, 0, lat, cs_n, rd_n, pg_n, rd_first, bad, ack_w, rd, er, to);
    e = exp_q.pop_front();
    checks++; if (to !== 1'b0 || lat !== e.lat) begin errors++; $display("FAIL prog_lat got %0d want %0d", lat, e.lat); end
    checks++; if (pg_n !== 2000) begin errors++; $display("FAIL prog_width got %0d want 2000", pg_n); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL prog_addr_dati got %0d want 0", bad); end
    checks++; if (cs_n !== exp_cs || rd_n !== exp_rd) begin errors++; $display("FAIL prog_cs_rd got %0d/%0d want %0d/%0d", cs_n, rd_n, exp_cs, exp_rd); end
    checks++; if (er !== e.err) begin errors++; $display("FAIL prog_err got %b want %b", er, e.err); end
    checks++; if (rd !== e.rdata) begin errors++; $display("FAIL prog_rdata got %h want %h", rd, e.rdata); end
    last_rdata = e.rdata;
  endtask

  task automatic test_prog_disallowed();
    bus.PROG_EN = 1'b0;
    exp_q.push_back('{owner: 1'b1, rdata: last_rdata, err: 1'b1, lat: 1});
    run_txn(1'b1, 1'b1, 7'h20, 8'hFF, -1, -1, 0, lat, cs_n, rd_n, pg_n, rd_first, bad, ack_w, rd, er, to);
    e = exp_q.pop_front();
    checks++; if (to !== 1'b0 || lat !== e.lat) begin errors++; $display("FAIL nope_lat got %0d want %0d", lat, e.lat); end
    checks++; if (cs_n !== 0 || pg_n !== 0) begin errors++; $display("FAIL nope_cs got %0d/%0d want 0/0", cs_n, pg_n); end
    checks++; if (er !== e.err) begin errors++; $display("FAIL nope_err got %b want %b", er, e.err); end
    checks++; if (rd !== e.rdata) begin errors++; $display("FAIL nope_rdata got %h want %h", rd, e.rdata); end
    bus.PROG_EN = 1'b1;
  endtask

  task automatic test_prog_en_drop();
    bus.PROG_EN = 1'b1;
    exp_q.push_back('{owner: 1'b1, rdata: last_rdata, err: 1'b1, lat: 104});
    run_txn(1'b1, 1'b1, 7'h11, 8'h81, -1, 100, 0, lat, cs_n, rd_n, pg_n, rd_first, bad, ack_w, rd, er, to);
    e = exp_q.pop_front();
    checks++; if (to !== 1'b0 || lat !== e.lat) begin errors++; $display("FAIL pedrop_lat got %0d want %0d", lat, e.lat); end
    checks++; if (pg_n !== 99) begin errors++; $display("FAIL pedrop_prog got %0d want 99", pg_n); end
    checks++; if (cs_n !== 103) begin errors++; $display("FAIL pedrop_cs got %0d want 103", cs_n); end
    checks++; if (er !== e.err) begin errors++; $display("FAIL pedrop_err got %b want %b", er, e.err); end
    checks++; if (rd !== e.rdata) begin errors++; $display("FAIL pedrop_rdata got %h want %h", rd, e.rdata); end
    bus.PROG_EN = 1'b1;
  endtask

  task automatic test_reset_mid_prog();
    bus.PROG_EN = 1'b1;
    bus.R1_REQ = 1'b1; bus.R1_WR = 1'b1; bus.R1_ADDR = 7'h12; bus.R1_WDATA = 8'h77;
    repeat (502) tick();
    checks++; if (bus.OTP_PROG !== 1'b1) begin errors++; $display("FAIL rstmid_pre_prog got %b want 1", bus.OTP_PROG); end
    #2 RESET = 1'b1;
    #1;
    checks++; if ({bus.OTP_PROG, bus.OTP_CS, bus.BUSY} !== 3'b000) begin errors++; $display("FAIL rstmid_async got %b want 000", {bus.OTP_PROG, bus.OTP_CS, bus.BUSY}); end
    bus.R1_REQ = 1'b0;
    repeat (2) tick();
    RESET = 1'b0;
    ackcnt = 0;
    repeat (20) begin
      tick();
      if (bus.R0_ACK || bus.R1_ACK) ackcnt++;
    end
    checks++; if (ackcnt !== 0) begin errors++; $display("FAIL rstmid_no_ack got %0d want 0", ackcnt); end
    bus.OTP_DATO = 8'h4B;
    exp_q.push_back('{owner: 1'b0, rdata: 8'h4B, err: 1'b0, lat: 9});
    run_txn(1'b0, 1'b0, 7'h33, 8'h00, -1, -1, 0, lat, cs_n, rd_n, pg_n, rd_first, bad, ack_w, rd, er, to);
    e = exp_q.pop_front();
    checks++; if (to !== 1'b0 || lat !== e.lat) begin errors++; $display("FAIL rstmid_r0_lat got %0d want %0d", lat, e.lat); end
    checks++; if (rd !== e.rdata) begin errors++; $display("FAIL rstmid_r0_rdata got %h want %h", rd, e.rdata); end
  endtask

  task automatic test_early_drop();
    bus.OTP_DATO = 8'hC3;
    exp_q.push_back('{owner: 1'b0, rdata: 8'hC3, err: 1'b0, lat: 9});
    run_txn(1'b0, 1'b0, 7'h22, 8'h00, 1, -1, 0, lat, cs_n, rd_n, pg_n, rd_first, bad, ack_w, rd, er, to);
    e = exp_q.pop_front();
    checks++; if (to !== 1'b0 || lat !== e.lat) begin errors++; $display("FAIL early_lat got %0d want %0d", lat, e.lat); end
    checks++; if (cs_n !== 8 || rd_n !== 4) begin errors++; $display("FAIL early_cycle got %0d/%0d want 8/4", cs_n, rd_n); end
    checks++; if (ack_w !== 1) begin errors++; $display("FAIL early_ack_pulse got %0d want 1", ack_w); end
    checks++; if (rd !== e.rdata) begin errors++; $display("FAIL early_rdata got %h want %h", rd, e.rdata); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_arbitration();
    test_program();
    test_prog_disallowed();
    test_prog_en_drop();
    test_reset_mid_prog();
    test_early_drop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
